// File: rtl/ssd1306_pkg.sv
// rtl/ssd1306_pkg.sv - shared opcodes, addressing modes and FSM states for the SSD1306 SPI sink
package ssd1306_pkg;

  localparam logic [7:0] OP_SET_MODE    = 8'h20;
  localparam logic [7:0] OP_COL_ADDR    = 8'h21;
  localparam logic [7:0] OP_PAGE_ADDR   = 8'h22;
  localparam logic [7:0] OP_CONTRAST    = 8'h81;
  localparam logic [7:0] OP_CHARGE_PUMP = 8'h8D;
  localparam logic [7:0] OP_NORMAL      = 8'hA6;
  localparam logic [7:0] OP_INVERT      = 8'hA7;
  localparam logic [7:0] OP_MUX_RATIO   = 8'hA8;
  localparam logic [7:0] OP_DISP_OFF    = 8'hAE;
  localparam logic [7:0] OP_DISP_ON     = 8'hAF;
  localparam logic [7:0] OP_DISP_OFFSET = 8'hD3;
  localparam logic [7:0] OP_CLK_DIV     = 8'hD5;
  localparam logic [7:0] OP_PRECHARGE   = 8'hD9;
  localparam logic [7:0] OP_COM_PINS    = 8'hDA;
  localparam logic [7:0] OP_VCOMH       = 8'hDB;

  typedef enum logic [1:0] {
    MODE_HORZ = 2'b00,
    MODE_VERT = 2'b01,
    MODE_PAGE = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    CMD  = 2'd0,
    ARG1 = 2'd1,
    ARG2 = 2'd2
  } state_e;

  // Requests from the command decoder to the address generator.
  typedef enum logic [3:0] {
    AG_NONE,
    AG_ADVANCE,
    AG_MODE,
    AG_COL_START,
    AG_COL_END,
    AG_PAGE_START,
    AG_PAGE_END,
    AG_COL_LO,
    AG_COL_HI,
    AG_PAGE
  } ag_op_e;

endpackage

// File: rtl/ssd1306_addr_gen.sv
// rtl/ssd1306_addr_gen.sv - column/page counters, window registers and auto-increment
module ssd1306_addr_gen
  import ssd1306_pkg::*;
#(
  parameter int COLS  = 128,
  parameter int PAGES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  ag_op_e                   op_i,
  input  logic [$clog2(COLS)-1:0]  arg_i,
  output logic [$clog2(COLS)-1:0]  col_o,
  output logic [$clog2(PAGES)-1:0] page_o
);

  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(PAGES);

  mode_e          mode_q, mode_d;
  logic [CW-1:0]  col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
  logic [PW-1:0]  page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
  logic [CW-1:0]  col_step;
  logic [PW-1:0]  page_step;

  // Wrap is by equality only, so an inverted window rolls through zero.
  assign col_step  = (col_q == col_end_q)   ? col_start_q  : col_q + CW'(1);
  assign page_step = (page_q == page_end_q) ? page_start_q : page_q + PW'(1);

  always_comb begin
    mode_d       = mode_q;
    col_d        = col_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_d       = page_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    case (op_i)
      AG_ADVANCE: begin
        case (mode_q)
          MODE_HORZ: begin
            if (col_q == col_end_q) begin
              col_d  = col_start_q;
              page_d = page_step;
            end else begin
              col_d = col_q + CW'(1);
            end
          end
          MODE_VERT: begin
            if (page_q == page_end_q) begin
              page_d = page_start_q;
              col_d  = col_step;
            end else begin
              page_d = page_q + PW'(1);
            end
          end
          default: col_d = col_step;
        endcase
      end
      AG_MODE:       mode_d = (arg_i[1:0] == 2'b11) ? MODE_PAGE : mode_e'(arg_i[1:0]);
      AG_COL_START:  col_start_d = arg_i;
      AG_COL_END: begin
        col_end_d = arg_i;
        col_d     = col_start_q;
      end
      AG_PAGE_START: page_start_d = arg_i[PW-1:0];
      AG_PAGE_END: begin
        page_end_d = arg_i[PW-1:0];
        page_d     = page_start_q;
      end
      AG_COL_LO:     col_d[3:0] = arg_i[3:0];
      AG_COL_HI:     col_d[CW-1:4] = arg_i[CW-5:0];
      AG_PAGE:       page_d = arg_i[PW-1:0];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q       <= MODE_PAGE;
      col_q        <= '0;
      col_start_q  <= '0;
      col_end_q    <= CW'(COLS - 1);
      page_q       <= '0;
      page_start_q <= '0;
      page_end_q   <= PW'(PAGES - 1);
    end else begin
      mode_q       <= mode_d;
      col_q        <= col_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_q       <= page_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
    end
  end

  assign col_o  = col_q;
  assign page_o = page_q;

endmodule

// File: rtl/ssd1306_spi_sink.sv
// rtl/ssd1306_spi_sink.sv - SSD1306 SPI front end: deserialiser, command FSM, framebuffer writes
module ssd1306_spi_sink
  import ssd1306_pkg::*;
#(
  parameter int COLS        = 128,
  parameter int PAGES       = 8,
  parameter int FB_ADDR_LEN = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sck,
  input  logic                   mosi,
  input  logic                   cs_n,
  input  logic                   dc,
  output logic                   fb_we,
  output logic [FB_ADDR_LEN-1:0] fb_addr,
  output logic [7:0]             fb_data,
  output logic                   disp_on,
  output logic                   invert,
  output logic [7:0]             contrast
);

  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(PAGES);

  logic                   sck_q;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [6:0]             shreg_q, shreg_d;
  state_e                 state_q, state_d;
  logic [7:0]             pend_q, pend_d;
  logic                   fb_we_q, fb_we_d;
  logic [FB_ADDR_LEN-1:0] fb_addr_q, fb_addr_d;
  logic [7:0]             fb_data_q, fb_data_d;
  logic                   disp_on_q, disp_on_d;
  logic                   invert_q, invert_d;
  logic [7:0]             contrast_q, contrast_d;

  logic                   sck_rise, byte_done;
  logic [7:0]             rx_byte;
  ag_op_e                 ag_op;
  logic [CW-1:0]          col;
  logic [PW-1:0]          page;

  assign sck_rise  = sck & ~sck_q & ~cs_n;
  assign byte_done = sck_rise && (bit_cnt_q == 3'd7);
  assign rx_byte   = {shreg_q, mosi};

  ssd1306_addr_gen #(.COLS(COLS), .PAGES(PAGES)) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .op_i   (ag_op),
    .arg_i  (rx_byte[CW-1:0]),
    .col_o  (col),
    .page_o (page)
  );

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    state_d    = state_q;
    pend_d     = pend_q;
    fb_we_d    = 1'b0;
    fb_addr_d  = fb_addr_q;
    fb_data_d  = fb_data_q;
    disp_on_d  = disp_on_q;
    invert_d   = invert_q;
    contrast_d = contrast_q;
    ag_op      = AG_NONE;

    if (cs_n) begin
      bit_cnt_d = 3'd0;
    end else if (sck_rise) begin
      shreg_d   = rx_byte[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
    end

    if (byte_done) begin
      if (dc) begin
        // A data byte always lands, even if a command argument was pending.
        fb_we_d   = 1'b1;
        fb_addr_d = FB_ADDR_LEN'(page) * FB_ADDR_LEN'(COLS) + FB_ADDR_LEN'(col);
        fb_data_d = rx_byte;
        ag_op     = AG_ADVANCE;
        state_d   = CMD;
      end else begin
        case (state_q)
          CMD: begin
            case (rx_byte)
              OP_SET_MODE, OP_COL_ADDR, OP_PAGE_ADDR, OP_CONTRAST,
              OP_CHARGE_PUMP, OP_MUX_RATIO, OP_DISP_OFFSET, OP_CLK_DIV,
              OP_PRECHARGE, OP_COM_PINS, OP_VCOMH: begin
                state_d = ARG1;
                pend_d  = rx_byte;
              end
              OP_DISP_OFF: disp_on_d = 1'b0;
              OP_DISP_ON:  disp_on_d = 1'b1;
              OP_NORMAL:   invert_d  = 1'b0;
              OP_INVERT:   invert_d  = 1'b1;
              default: begin
                if (rx_byte[7:4] == 4'h0)        ag_op = AG_COL_LO;
                else if (rx_byte[7:3] == 5'b00010) ag_op = AG_COL_HI;
                else if (rx_byte[7:3] == 5'b10110) ag_op = AG_PAGE;
              end
            endcase
          end
          ARG1: begin
            state_d = CMD;
            case (pend_q)
              OP_SET_MODE:  ag_op = AG_MODE;
              OP_CONTRAST:  contrast_d = rx_byte;
              OP_COL_ADDR: begin
                ag_op   = AG_COL_START;
                state_d = ARG2;
              end
              OP_PAGE_ADDR: begin
                ag_op   = AG_PAGE_START;
                state_d = ARG2;
              end
              default: ;
            endcase
          end
          ARG2: begin
            state_d = CMD;
            if (pend_q == OP_COL_ADDR)       ag_op = AG_COL_END;
            else if (pend_q == OP_PAGE_ADDR) ag_op = AG_PAGE_END;
          end
          default: state_d = CMD;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_q      <= 1'b0;
      bit_cnt_q  <= 3'd0;
      shreg_q    <= 7'd0;
      state_q    <= CMD;
      pend_q     <= 8'd0;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_data_q  <= 8'd0;
      disp_on_q  <= 1'b0;
      invert_q   <= 1'b0;
      contrast_q <= 8'h7F;
    end else begin
      sck_q      <= sck;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      state_q    <= state_d;
      pend_q     <= pend_d;
      fb_we_q    <= fb_we_d;
      fb_addr_q  <= fb_addr_d;
      fb_data_q  <= fb_data_d;
      disp_on_q  <= disp_on_d;
      invert_q   <= invert_d;
      contrast_q <= contrast_d;
    end
  end

  assign fb_we    = fb_we_q;
  assign fb_addr  = fb_addr_q;
  assign fb_data  = fb_data_q;
  assign disp_on  = disp_on_q;
  assign invert   = invert_q;
  assign contrast = contrast_q;

endmodule

// File: tb/tb_ssd1306_spi_sink.sv
// tb/tb_ssd1306_spi_sink.sv - table-driven and sequence checks for ssd1306_spi_sink
module tb_ssd1306_spi_sink;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sck = 1'b0;
  logic       mosi = 1'b0;
  logic       cs_n = 1'b1;
  logic       dc = 1'b0;
  logic       fb_we;
  logic [9:0] fb_addr;
  logic [7:0] fb_data;
  logic       disp_on;
  logic       invert;
  logic [7:0] contrast;

  int passed = 0;
  int total  = 0;
  int dbl    = 0;
  logic we_prev = 1'b0;
  logic [17:0] wq[$];

  typedef struct {
    bit         rst;
    bit         dc;
    logic [7:0] val;
    bit         we;
    logic [9:0] addr;
    logic [7:0] con;
    bit         don;
    bit         inv;
  } vec_t;

  vec_t tbl[$];

  ssd1306_spi_sink dut (
    .clk      (clk),
    .rst      (rst),
    .sck      (sck),
    .mosi     (mosi),
    .cs_n     (cs_n),
    .dc       (dc),
    .fb_we    (fb_we),
    .fb_addr  (fb_addr),
    .fb_data  (fb_data),
    .disp_on  (disp_on),
    .invert   (invert),
    .contrast (contrast)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fb_we) begin
      wq.push_back({fb_addr, fb_data});
      if (we_prev) dbl++;
    end
    we_prev = fb_we;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic void add(input bit r, input bit d, input logic [7:0] v, input bit we,
                              input logic [9:0] a, input logic [7:0] c, input bit dn, input bit iv);
    vec_t t;
    t.rst = r; t.dc = d; t.val = v; t.we = we; t.addr = a; t.con = c; t.don = dn; t.inv = iv;
    tbl.push_back(t);
  endfunction

  task automatic do_reset();
    cs_n = 1'b1; sck = 1'b0; mosi = 1'b0; dc = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    cs_n = 1'b0;
    wq.delete();
  endtask

  task automatic send_bits(input logic d, input logic [7:0] v, input int n, input int half);
    for (int b = 7; b > 7 - n; b--) begin
      mosi = v[b]; dc = d; sck = 1'b0;
      repeat (half) @(posedge clk);
      #1 sck = 1'b1;
      repeat (half) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic d, input logic [7:0] v, input int half);
    send_bits(d, v, 8, half);
    sck = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic cmds(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                      input logic [7:0] b3, input int n);
    logic [7:0] bs [4];
    bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
    for (int k = 0; k < n; k++) send_byte(1'b0, bs[k], 1);
  endtask

  task automatic check_write(input string nm, input logic [9:0] a, input logic [7:0] d);
    logic [17:0] e;
    check({nm, "_cnt"}, wq.size(), 1);
    if (wq.size() > 0) begin
      e = wq.pop_front();
      check({nm, "_ad"}, e, {a, d});
    end
    wq.delete();
  endtask

  initial begin
    // vertical mode window 0x10..0x11, pages 2..3
    add(1,0,8'h20,0,0,8'h7F,0,0); add(0,0,8'h01,0,0,8'h7F,0,0);
    add(0,0,8'h21,0,0,8'h7F,0,0); add(0,0,8'h10,0,0,8'h7F,0,0); add(0,0,8'h11,0,0,8'h7F,0,0);
    add(0,0,8'h22,0,0,8'h7F,0,0); add(0,0,8'h02,0,0,8'h7F,0,0); add(0,0,8'h03,0,0,8'h7F,0,0);
    add(0,1,8'hA1,1,10'h110,8'h7F,0,0); add(0,1,8'hA2,1,10'h190,8'h7F,0,0);
    add(0,1,8'hA3,1,10'h111,8'h7F,0,0); add(0,1,8'hA4,1,10'h191,8'h7F,0,0);
    add(0,1,8'hA5,1,10'h110,8'h7F,0,0);
    // page mode defaults, page/col set commands
    add(1,0,8'hB3,0,0,8'h7F,0,0); add(0,0,8'h05,0,0,8'h7F,0,0); add(0,0,8'h12,0,0,8'h7F,0,0);
    add(0,1,8'h11,1,10'h1A5,8'h7F,0,0); add(0,1,8'h22,1,10'h1A6,8'h7F,0,0);
    // page mode column wrap at col_end=3
    add(1,0,8'h21,0,0,8'h7F,0,0); add(0,0,8'h00,0,0,8'h7F,0,0); add(0,0,8'h03,0,0,8'h7F,0,0);
    add(0,0,8'hB1,0,0,8'h7F,0,0); add(0,0,8'h03,0,0,8'h7F,0,0);
    add(0,1,8'h33,1,10'h083,8'h7F,0,0); add(0,1,8'h44,1,10'h080,8'h7F,0,0);
    // registers; 8D consumes 14 so it must not set the column high nibble
    add(1,0,8'h81,0,0,8'h7F,0,0); add(0,0,8'hCF,0,0,8'hCF,0,0); add(0,0,8'hAF,0,0,8'hCF,1,0);
    add(0,0,8'hA7,0,0,8'hCF,1,1); add(0,0,8'h8D,0,0,8'hCF,1,1); add(0,0,8'h14,0,0,8'hCF,1,1);
    add(0,1,8'h55,1,10'h000,8'hCF,1,1); add(0,0,8'hAE,0,0,8'hCF,0,1); add(0,0,8'hA6,0,0,8'hCF,0,0);
    // mode argument 3 behaves as page mode
    add(1,0,8'h20,0,0,8'h7F,0,0); add(0,0,8'h03,0,0,8'h7F,0,0);
    add(0,0,8'h21,0,0,8'h7F,0,0); add(0,0,8'h00,0,0,8'h7F,0,0); add(0,0,8'h01,0,0,8'h7F,0,0);
    add(0,1,8'h61,1,10'h000,8'h7F,0,0); add(0,1,8'h62,1,10'h001,8'h7F,0,0);
    add(0,1,8'h63,1,10'h000,8'h7F,0,0);

    do_reset();
    check("rst_we", fb_we, 0);
    check("rst_addr", fb_addr, 0);
    check("rst_data", fb_data, 0);
    check("rst_disp", disp_on, 0);
    check("rst_inv", invert, 0);
    check("rst_contrast", contrast, 8'h7F);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      wq.delete();
      send_byte(tbl[i].dc, tbl[i].val, 2);
      check($sformatf("row%0d_wcnt", i), wq.size(), tbl[i].we);
      if (tbl[i].we && wq.size() > 0)
        check($sformatf("row%0d_write", i), wq[0], {tbl[i].addr, tbl[i].val});
      check($sformatf("row%0d_contrast", i), contrast, tbl[i].con);
      check($sformatf("row%0d_disp", i), disp_on, tbl[i].don);
      check($sformatf("row%0d_inv", i), invert, tbl[i].inv);
    end

    // horizontal fill of the whole framebuffer, then wrap to 0
    do_reset();
    cmds(8'h20, 8'h00, 8'h21, 8'h00, 4);
    cmds(8'h7F, 8'h22, 8'h00, 8'h07, 4);
    wq.delete();
    for (int i = 0; i < 1025; i++) begin
      send_byte(1'b1, 8'(i), 1);
      check_write($sformatf("fill%0d", i), 10'(i % 1024), 8'(i));
    end

    // partial byte discarded when cs_n rises
    do_reset();
    send_bits(1'b1, 8'hFF, 5, 2);
    sck = 1'b0; cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 cs_n = 1'b0;
    send_byte(1'b1, 8'h5A, 2);
    check_write("cs_abort", 10'h000, 8'h5A);

    // data byte aborts a pending 0x21 argument
    do_reset();
    cmds(8'h21, 8'h05, 8'h00, 8'h00, 2);
    wq.delete();
    send_byte(1'b1, 8'h77, 2);
    check("arg_abort_cnt", wq.size(), 1);
    if (wq.size() > 0) check("arg_abort_data", wq[0][7:0], 8'h77);
    send_byte(1'b0, 8'hAF, 2);
    check("arg_abort_cmd", disp_on, 1);

    // one-cycle latency from the final sck rise
    do_reset();
    send_bits(1'b1, 8'hC3, 7, 2);
    mosi = 1'b1; sck = 1'b0;
    repeat (2) @(posedge clk);
    #1 sck = 1'b1;
    check("lat_pre", fb_we, 0);
    @(posedge clk); #1;
    check("lat_we", fb_we, 1);
    check("lat_data", fb_data, 8'hC3);
    @(posedge clk); #1;
    check("lat_post", fb_we, 0);
    sck = 1'b0;
    repeat (3) @(posedge clk); #1;

    // divider 0 streaming
    do_reset();
    for (int i = 0; i < 16; i++) begin
      send_byte(1'b1, 8'(i * 17), 1);
      check_write($sformatf("stress%0d", i), 10'(i), 8'(i * 17));
    end
    check("no_double_we", dbl, 0);

    // asynchronous reset mid-byte
    do_reset();
    cmds(8'h81, 8'hCF, 8'hAF, 8'hA7, 4);
    send_byte(1'b1, 8'h99, 1);
    send_bits(1'b1, 8'hF0, 4, 2);
    #3 rst = 1'b0;
    #1;
    check("arst_we", fb_we, 0);
    check("arst_addr", fb_addr, 0);
    check("arst_data", fb_data, 0);
    check("arst_disp", disp_on, 0);
    check("arst_inv", invert, 0);
    check("arst_contrast", contrast, 8'h7F);
    sck = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    wq.delete();
    send_byte(1'b1, 8'hAB, 2);
    check_write("arst_next", 10'h000, 8'hAB);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
